// File: rtl/dcache_ram_pkg.sv
// Shared types and helpers for the byte-enabled D-cache simple-dual-port RAM.
// Provides the clear-engine state type and the per-lane merge used by collision forwarding.
package dcache_ram_pkg;

    typedef enum logic {
        IDLE,
        CLEAR
    } dcache_ram_state_e;

    // Upper bound on word width supported by be_merge; callers zero-extend into it.
    localparam int unsigned MAX_DATA_WIDTH = 256;
    localparam int unsigned MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

    function automatic bit byte_size_legal(input int unsigned byte_size,
                                           input int unsigned data_width);
        return (byte_size == 8 || byte_size == 9) && (data_width > 0) &&
               (data_width % byte_size == 0) && (data_width <= MAX_DATA_WIDTH);
    endfunction

    function automatic logic [MAX_DATA_WIDTH-1:0] be_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_data,
        input logic [MAX_DATA_WIDTH-1:0] new_data,
        input logic [MAX_BE_WIDTH-1:0]   be,
        input int unsigned               byte_size
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) begin
            merged[i] = be[i / byte_size] ? new_data[i] : old_data[i];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dcache_ram_core.sv
// Plain byte-enabled simple-dual-port array: synchronous write, synchronous read, no reset.
// Kept free of control logic so vendor block-RAM inference sees a textbook template.
module dcache_ram_core #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_SIZE  = 8,
    localparam int unsigned BE_WIDTH  = DATA_WIDTH / BYTE_SIZE
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BE_WIDTH-1:0]   wbe,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read-before-write on collision; the top merges fresh lanes after the array.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < BE_WIDTH; i++) begin
                if (wbe[i]) begin
                    mem[waddr][i*BYTE_SIZE +: BYTE_SIZE] <= wdata[i*BYTE_SIZE +: BYTE_SIZE];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dcache_sdpram_be_fwd.sv
// D-cache data RAM: byte-enabled SDP array with write-first collision forwarding,
// optional output register, rd_valid pipeline and a zero-fill clear engine.
module dcache_sdpram_be_fwd
    import dcache_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BYTE_SIZE    = 8,
    parameter bit          OUTPUT_REG   = 1'b0,
    parameter bit          CLEAR_ON_RST = 1'b1,
    localparam int unsigned BE_WIDTH    = DATA_WIDTH / BYTE_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BE_WIDTH-1:0]   wr_byte_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    if (!byte_size_legal(BYTE_SIZE, DATA_WIDTH)) begin : g_bad_cfg
        $error("dcache_sdpram_be_fwd: illegal BYTE_SIZE/DATA_WIDTH combination");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    dcache_ram_state_e     state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RST ? CLEAR : IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == CLEAR);

    logic rd_acc;
    logic wr_acc;
    assign rd_acc = rd_en & ~busy;
    assign wr_acc = wr_en & ~busy;

    // Clear engine steals the write port; user accesses are dropped while it runs.
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [BE_WIDTH-1:0]   ram_wbe;
    logic [DATA_WIDTH-1:0] ram_rdata;

    always_comb begin
        ram_we    = wr_acc;
        ram_waddr = wr_addr;
        ram_wdata = wr_data;
        ram_wbe   = wr_byte_en;
        if (busy) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt_q;
            ram_wdata = '0;
            ram_wbe   = '1;
        end
    end

    dcache_ram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_SIZE  (BYTE_SIZE)
    ) u_core (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .wbe   (ram_wbe),
        .re    (rd_acc),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // Collision side-band only moves with an accepted read, so the merged word holds between reads.
    logic                  vld1_q;
    logic                  hit_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld1_q  <= 1'b0;
            hit_q   <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            vld1_q <= rd_acc;
            if (rd_acc) begin
                hit_q   <= wr_acc && (wr_addr == rd_addr);
                be_q    <= wr_byte_en;
                wdata_q <= wr_data;
            end
        end
    end

    logic [MAX_DATA_WIDTH-1:0] merged_full;
    logic [DATA_WIDTH-1:0]     merged;
    logic                      unused_merged;

    assign merged_full   = be_merge(MAX_DATA_WIDTH'(ram_rdata), MAX_DATA_WIDTH'(wdata_q),
                                    MAX_BE_WIDTH'(be_q), BYTE_SIZE);
    assign merged        = hit_q ? merged_full[DATA_WIDTH-1:0] : ram_rdata;
    assign unused_merged = ^merged_full;

    if (OUTPUT_REG) begin : g_out_reg
        logic                  vld2_q;
        logic [DATA_WIDTH-1:0] out_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld2_q <= 1'b0;
                out_q  <= '0;
            end else begin
                vld2_q <= vld1_q;
                if (vld1_q) begin
                    out_q <= merged;
                end
            end
        end

        assign rd_data  = out_q;
        assign rd_valid = vld2_q;
    end else begin : g_out_comb
        // The array output register has no reset; mask it until a read has landed.
        logic have_data_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                have_data_q <= 1'b0;
            end else if (rd_acc) begin
                have_data_q <= 1'b1;
            end
        end

        assign rd_data  = have_data_q ? merged : '0;
        assign rd_valid = vld1_q;
    end

endmodule

// File: tb/tb_dcache_sdpram_be_fwd.sv
// Randomised self-checking bench: two instances (OUTPUT_REG 0 and 1) share stimulus and are
// compared every cycle against a behavioural array/queue model, plus directed scenarios.
module tb_dcache_sdpram_be_fwd;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr_req = 1'b0;
    logic        wr_en = 1'b0;
    logic [8:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_byte_en = '0;
    logic        rd_en = 1'b0;
    logic [8:0]  rd_addr = '0;

    logic        busy0, busy1, rd_valid0, rd_valid1;
    logic [31:0] rd_data0, rd_data1;

    always #5 clk = ~clk;

    dcache_sdpram_be_fwd #(.OUTPUT_REG(1'b0), .CLEAR_ON_RST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0)
    );

    dcache_sdpram_be_fwd #(.OUTPUT_REG(1'b1), .CLEAR_ON_RST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: word array, remaining-clear count, and the last result per latency.
    logic [31:0] m_mem [DEPTH];
    int          clr_left;
    logic        exp_busy, exp_v0, exp_v1, prev_issued;
    logic [31:0] exp_d0, exp_d1, prev_data;

    task automatic model_reset();
        clr_left    = DEPTH;
        exp_busy    = 1'b1;
        exp_v0      = 1'b0;
        exp_v1      = 1'b0;
        exp_d0      = '0;
        exp_d1      = '0;
        prev_issued = 1'b0;
        prev_data   = '0;
    endtask

    task automatic model_edge();
        logic        issued;
        logic [31:0] rv;
        issued = 1'b0;
        rv     = '0;
        if (rst) return;
        if (clr_left > 0) begin
            m_mem[DEPTH - clr_left] = '0;
            clr_left--;
        end else begin
            if (rd_en) begin
                issued = 1'b1;
                rv     = m_mem[rd_addr];
                if (wr_en && wr_addr == rd_addr) begin
                    for (int l = 0; l < 4; l++) begin
                        if (wr_byte_en[l]) rv[l*8 +: 8] = wr_data[l*8 +: 8];
                    end
                end
            end
            if (wr_en) begin
                for (int l = 0; l < 4; l++) begin
                    if (wr_byte_en[l]) m_mem[wr_addr][l*8 +: 8] = wr_data[l*8 +: 8];
                end
            end
            if (clr_req) clr_left = DEPTH;
        end
        exp_v0 = issued;
        if (issued) exp_d0 = rv;
        exp_v1 = prev_issued;
        if (prev_issued) exp_d1 = prev_data;
        prev_issued = issued;
        prev_data   = rv;
        exp_busy    = (clr_left > 0);
    endtask

    task automatic check_outputs();
        check_eq("busy0", {31'd0, busy0}, {31'd0, exp_busy});
        check_eq("busy1", {31'd0, busy1}, {31'd0, exp_busy});
        check_eq("rd_valid0", {31'd0, rd_valid0}, {31'd0, exp_v0});
        check_eq("rd_valid1", {31'd0, rd_valid1}, {31'd0, exp_v1});
        check_eq("rd_data0", rd_data0, exp_d0);
        check_eq("rd_data1", rd_data1, exp_d1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic do_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_byte_en = be;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [8:0] a);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (busy0 === 1'b1 && n < 4 * DEPTH) begin
            step();
            n++;
        end
        check_eq(tag, n, DEPTH);
    endtask

    task automatic assert_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        check_eq({tag, "_busy"}, {31'd0, busy0}, 32'd1);
        check_eq({tag, "_valid0"}, {31'd0, rd_valid0}, 32'd0);
        check_eq({tag, "_valid1"}, {31'd0, rd_valid1}, 32'd0);
        check_eq({tag, "_data0"}, rd_data0, 32'd0);
        check_eq({tag, "_data1"}, rd_data1, 32'd0);
    endtask

    initial begin
        logic [31:0] pat;

        // 1: reset, full-length clear, top word reads zero
        #2;
        assert_reset("rst0");
        step();
        step();
        rst = 1'b0;
        wait_clear("t1_clear_len");
        do_read(9'h1FF);
        check_eq("t1_rd0", rd_data0, 32'h0);
        check_eq("t1_v0", {31'd0, rd_valid0}, 32'd1);
        step();
        check_eq("t1_rd1", rd_data1, 32'h0);

        // 2: partial byte-enable overwrite, latency 1 vs 2
        do_write(9'h010, 32'hAABBCCDD, 4'b1111);
        do_write(9'h010, 32'h11223344, 4'b0101);
        do_read(9'h010);
        check_eq("t2_v0", {31'd0, rd_valid0}, 32'd1);
        check_eq("t2_v1_early", {31'd0, rd_valid1}, 32'd0);
        check_eq("t2_d0", rd_data0, 32'hAA22CC44);
        step();
        check_eq("t2_v0_pulse", {31'd0, rd_valid0}, 32'd0);
        check_eq("t2_v1", {31'd0, rd_valid1}, 32'd1);
        check_eq("t2_d1", rd_data1, 32'hAA22CC44);
        check_eq("t2_d0_hold", rd_data0, 32'hAA22CC44);

        // 3: same-cycle collision forwarding
        do_write(9'h020, 32'h12345678, 4'b1111);
        wr_en = 1'b1; wr_addr = 9'h020; wr_data = 32'hFFFFFFFF; wr_byte_en = 4'b1100;
        rd_en = 1'b1; rd_addr = 9'h020;
        step();
        idle();
        check_eq("t3_fwd0", rd_data0, 32'hFFFF5678);
        step();
        check_eq("t3_fwd1", rd_data1, 32'hFFFF5678);
        do_read(9'h020);
        check_eq("t3_after", rd_data0, 32'hFFFF5678);

        // 4: back-to-back reads
        for (int i = 0; i < 8; i++) begin
            pat = 32'h01010101 * i;
            do_write(9'(i), pat, 4'b1111);
        end
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1; rd_addr = 9'(i);
            step();
            pat = 32'h01010101 * i;
            check_eq("t4_v0", {31'd0, rd_valid0}, 32'd1);
            check_eq("t4_d0", rd_data0, pat);
        end
        idle();
        step();
        step();

        // 5: clear request alongside accesses, accesses dropped while busy
        wr_en = 1'b1; wr_addr = 9'h030; wr_data = 32'hDEADBEEF; wr_byte_en = 4'hF;
        rd_en = 1'b1; rd_addr = 9'h010; clr_req = 1'b1;
        step();
        check_eq("t5_acc_v0", {31'd0, rd_valid0}, 32'd1);
        check_eq("t5_acc_d0", rd_data0, 32'hAA22CC44);
        begin
            int n;
            n = 0;
            while (busy0 === 1'b1 && n < 4 * DEPTH) begin
                rd_en = 1'($urandom_range(0, 1)); rd_addr = 9'($urandom_range(0, 63));
                wr_en = 1'($urandom_range(0, 1)); wr_addr = 9'($urandom_range(0, 63));
                wr_data = $urandom; wr_byte_en = 4'($urandom_range(0, 15));
                clr_req = 1'($urandom_range(0, 1));
                step();
                check_eq("t5_no_valid", {31'd0, rd_valid0}, 32'd0);
                n++;
            end
            check_eq("t5_clear_len", n, DEPTH);
        end
        idle();
        do_read(9'h030);
        check_eq("t5_rd30", rd_data0, 32'h0);
        do_read(9'h010);
        check_eq("t5_rd10", rd_data0, 32'h0);
        do_read(9'h020);
        check_eq("t5_rd20", rd_data0, 32'h0);

        // 6: reset in the middle of a clear
        do_read(9'h007);
        assert_reset("rst1");
        step();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) step();
        assert_reset("t6_mid");
        step();
        rst = 1'b0;
        wait_clear("t6_clear_len");

        // Random traffic over a small address window to provoke collisions
        for (int i = 0; i < 3000; i++) begin
            rd_en      = 1'($urandom_range(0, 1));
            rd_addr    = 9'($urandom_range(0, 15));
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = 9'($urandom_range(0, 15));
            wr_data    = $urandom;
            wr_byte_en = 4'($urandom_range(0, 15));
            clr_req    = ($urandom_range(0, 999) == 0);
            step();
        end
        idle();
        for (int i = 0; i < DEPTH + 4; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
